nibbler_core: RTL and testbench

- Parametrised next-generation accumulator processor core, generalising the 4-bit two-phase nibbler.
- Data width, address width and return-stack depth are parameters. Program and data memories are external ports.
- New over the previous generation: CALL/RET with a hardware return stack, HALT, a run/stall input, and a sticky stack-error flag.
- Sits between the program ROM / data RAM / pushbutton and LED glue at board top level.

---
 rtl/nibbler_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_nibbler_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibbler_core.sv
// Parametrised two-phase accumulator core: fetch/execute FSM, ALU with carry/zero,
// hardware return stack with sticky error, HALT state and a run/stall input.
module nibbler_core #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               run,
    input  logic [DATA_W-1:0]                  pushbuttons,
    output logic [ADDR_W-1:0]                  pmem_addr,
    input  logic [DATA_W+4:0]                  pmem_data,
    output logic [ADDR_W-1:0]                  dmem_addr,
    input  logic [DATA_W-1:0]                  dmem_rdata,
    output logic                               dmem_we,
    output logic [DATA_W-1:0]                  dmem_wdata,
    output logic [DATA_W-1:0]                  out_port,
    output logic [DATA_W-1:0]                  accu,
    output logic                               c_flag,
    output logic                               z_flag,
    output logic                               phase,
    output logic                               halted,
    output logic                               stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned STK_N = 1 << SP_W;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [4:0] {
        OP_JC    = 5'h00,
        OP_JNC   = 5'h01,
        OP_CMPI  = 5'h02,
        OP_CMPM  = 5'h03,
        OP_LIT   = 5'h04,
        OP_IN    = 5'h05,
        OP_LD    = 5'h06,
        OP_ST    = 5'h07,
        OP_JZ    = 5'h08,
        OP_JNZ   = 5'h09,
        OP_ADDI  = 5'h0A,
        OP_ADDM  = 5'h0B,
        OP_JMP   = 5'h0C,
        OP_OUT   = 5'h0D,
        OP_NANDI = 5'h0E,
        OP_NANDM = 5'h0F,
        OP_CALL  = 5'h10,
        OP_RET   = 5'h11,
        OP_HALT  = 5'h12
    } opcode_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n, pc_inc, target;
    logic [4:0]          instr, instr_n;
    logic [DATA_W-1:0]   oprnd, oprnd_n;
    logic [DATA_W-1:0]   accu_n, out_n;
    logic                c_n, z_n, err_n;
    logic [SP_W-1:0]     sp_n, sp_dec;
    logic [DATA_W:0]     alu;
    logic                alu_we, flag_we;
    logic                push, st_exec, stack_fault, halt_req;
    logic [ADDR_W-1:0]   stack_mem [STK_N];

    // In EXEC the second program word supplies the low part of the target.
    assign target = ADDR_W'({oprnd, pmem_data});
    assign pc_inc = pc + 1'b1;
    assign sp_dec = sp - 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else if (run) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH: state_n = S_EXEC;
            S_EXEC:  state_n = (halt_req || stack_fault) ? S_HALT : S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_comb begin
        pmem_addr  = pc;
        dmem_addr  = target;
        dmem_wdata = accu;
        phase      = (state == S_EXEC);
        halted     = (state == S_HALT);
        // Stalls and a reset arriving mid-EXEC both suppress the write at once.
        dmem_we    = st_exec && run && !reset;
    end

    always_comb begin
        pc_n        = pc;
        accu_n      = accu;
        c_n         = c_flag;
        z_n         = z_flag;
        out_n       = out_port;
        sp_n        = sp;
        err_n       = stack_err;
        instr_n     = instr;
        oprnd_n     = oprnd;
        alu         = '0;
        alu_we      = 1'b0;
        flag_we     = 1'b0;
        push        = 1'b0;
        st_exec     = 1'b0;
        stack_fault = 1'b0;
        halt_req    = 1'b0;

        case (state)
            S_FETCH: begin
                instr_n = pmem_data[DATA_W+4:DATA_W];
                oprnd_n = pmem_data[DATA_W-1:0];
                pc_n    = pc_inc;
            end
            S_EXEC: begin
                case (instr)
                    OP_JC:    pc_n = c_flag ? target : pc_inc;
                    OP_JNC:   pc_n = c_flag ? pc_inc : target;
                    OP_JZ:    pc_n = z_flag ? target : pc_inc;
                    OP_JNZ:   pc_n = z_flag ? pc_inc : target;
                    OP_JMP:   pc_n = target;
                    OP_CMPI: begin
                        alu     = {1'b0, accu} - {1'b0, oprnd};
                        flag_we = 1'b1;
                    end
                    OP_CMPM: begin
                        alu     = {1'b0, accu} - {1'b0, dmem_rdata};
                        flag_we = 1'b1;
                        pc_n    = pc_inc;
                    end
                    OP_LIT: begin
                        alu     = {1'b0, oprnd};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                    end
                    OP_IN: begin
                        alu     = {1'b0, pushbuttons};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                    end
                    OP_LD: begin
                        alu     = {1'b0, dmem_rdata};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                        pc_n    = pc_inc;
                    end
                    OP_ST: begin
                        st_exec = 1'b1;
                        pc_n    = pc_inc;
                    end
                    OP_ADDI: begin
                        alu     = {1'b0, accu} + {1'b0, oprnd};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                    end
                    OP_ADDM: begin
                        alu     = {1'b0, accu} + {1'b0, dmem_rdata};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                        pc_n    = pc_inc;
                    end
                    OP_OUT:   out_n = accu;
                    OP_NANDI: begin
                        alu     = {1'b0, ~(accu & oprnd)};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                    end
                    OP_NANDM: begin
                        alu     = {1'b0, ~(accu & dmem_rdata)};
                        flag_we = 1'b1;
                        alu_we  = 1'b1;
                        pc_n    = pc_inc;
                    end
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            stack_fault = 1'b1;
                            err_n       = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + 1'b1;
                            pc_n = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            stack_fault = 1'b1;
                            err_n       = 1'b1;
                        end else begin
                            pc_n = stack_mem[sp_dec];
                            sp_n = sp_dec;
                        end
                    end
                    OP_HALT:  halt_req = 1'b1;
                    default:  ;
                endcase

                if (flag_we) begin
                    c_n = alu[DATA_W];
                    z_n = (alu[DATA_W-1:0] == '0);
                end
                if (alu_we) begin
                    accu_n = alu[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            accu      <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            out_port  <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            instr     <= '0;
            oprnd     <= '0;
        end else if (run) begin
            pc        <= pc_n;
            accu      <= accu_n;
            c_flag    <= c_n;
            z_flag    <= z_n;
            out_port  <= out_n;
            sp        <= sp_n;
            stack_err <= err_n;
            instr     <= instr_n;
            oprnd     <= oprnd_n;
        end
    end

    // Return address is the word after the CALL's second word.
    always_ff @(posedge clock) begin
        if (run && push) begin
            stack_mem[sp] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_nibbler_core.sv
// Scoreboard bench for nibbler_core: an instruction-level interpreter predicts the
// architectural state after every instruction and every data write; a monitor compares.
module tb_nibbler_core;

    localparam int DW  = 4;
    localparam int AW  = 12;
    localparam int SD  = 2;
    localparam int SPW = $clog2(SD + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b0;
    logic [DW-1:0]   pushbuttons = '0;
    logic [AW-1:0]   pmem_addr;
    logic [DW+4:0]   pmem_data;
    logic [AW-1:0]   dmem_addr;
    logic [DW-1:0]   dmem_rdata;
    logic            dmem_we;
    logic [DW-1:0]   dmem_wdata;
    logic [DW-1:0]   out_port;
    logic [DW-1:0]   accu;
    logic            c_flag, z_flag, phase, halted, stack_err;
    logic [SPW-1:0]  sp;

    logic [8:0]      pmem [4096];
    logic [3:0]      dmem [4096];

    int n_cmp = 0;
    int n_bad = 0;

    logic [25:0] exp_q [$];
    logic [15:0] wr_q  [$];

    int          m_pc, m_acc, m_out;
    bit          m_c, m_z, m_err, m_halt;
    int          stk [$];
    logic [3:0]  mdmem [4096];

    nibbler_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clock(clk), .reset(reset), .run(run), .pushbuttons(pushbuttons),
        .pmem_addr(pmem_addr), .pmem_data(pmem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .out_port(out_port), .accu(accu),
        .c_flag(c_flag), .z_flag(z_flag), .phase(phase), .halted(halted),
        .stack_err(stack_err), .sp(sp)
    );

    always #5 clk = ~clk;

    assign pmem_data  = pmem[pmem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h, required nothing", name, act);
    endtask

    // Monitor: retire = EXEC leaving to FETCH or HALT; every write strobe pops the write queue.
    initial begin
        logic        prev_ph;
        logic [25:0] e;
        logic [15:0] w;
        prev_ph = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ph = 1'b0;
            end else begin
                if (!run) check("stall-we", {31'd0, dmem_we}, 32'd0);
                if (dmem_we) begin
                    if (wr_q.size() == 0) unexpected("write", {16'd0, dmem_addr, dmem_wdata});
                    else begin
                        w = wr_q.pop_front();
                        check("write", {16'd0, dmem_addr, dmem_wdata}, {16'd0, w});
                    end
                end
                if (prev_ph && !phase) begin
                    if (exp_q.size() == 0)
                        unexpected("retire", {6'd0, pmem_addr, accu, c_flag, z_flag, out_port, sp, stack_err, halted});
                    else begin
                        e = exp_q.pop_front();
                        check("retire", {6'd0, pmem_addr, accu, c_flag, z_flag, out_port, sp, stack_err, halted},
                              {6'd0, e});
                    end
                end
                prev_ph = phase;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic load_nop();
        for (int i = 0; i < 4096; i++) begin
            pmem[i] = 9'h130;
            dmem[i] = 4'h0;
        end
    endtask

    task automatic model_init();
        m_pc = 0; m_acc = 0; m_out = 0;
        m_c = 0; m_z = 0; m_err = 0; m_halt = 0;
        stk.delete();
        for (int i = 0; i < 4096; i++) mdmem[i] = dmem[i];
    endtask

    task automatic set_flags_load(input int b);
        m_acc = b; m_c = 0; m_z = (b == 0);
    endtask

    // Interpreter: one call = one instruction, straight from the opcode definitions.
    task automatic model_run(input int n, output int steps);
        logic [8:0] w1, w2;
        int op, opr, tgt, nxt, r, b;
        steps = 0;
        while (steps < n && !m_halt) begin
            w1   = pmem[m_pc];
            op   = int'(w1[8:4]);
            opr  = int'(w1[3:0]);
            m_pc = (m_pc + 1) % 4096;
            w2   = pmem[m_pc];
            tgt  = (opr * 512 + int'(w2)) % 4096;
            nxt  = (m_pc + 1) % 4096;
            b    = (op == 3 || op == 6 || op == 11 || op == 15) ? int'(mdmem[tgt]) : opr;
            case (op)
                0:  m_pc = m_c ? tgt : nxt;
                1:  m_pc = m_c ? nxt : tgt;
                8:  m_pc = m_z ? tgt : nxt;
                9:  m_pc = m_z ? nxt : tgt;
                12: m_pc = tgt;
                2, 3: begin
                    r = m_acc - b; m_c = (r < 0); m_z = (r == 0);
                    if (op == 3) m_pc = nxt;
                end
                4:  set_flags_load(opr);
                5:  set_flags_load(int'(pushbuttons));
                6:  begin set_flags_load(b); m_pc = nxt; end
                7:  begin
                    mdmem[tgt] = 4'(m_acc);
                    wr_q.push_back({12'(tgt), 4'(m_acc)});
                    m_pc = nxt;
                end
                10, 11: begin
                    r = m_acc + b; m_c = (r > 15); m_acc = r % 16; m_z = (m_acc == 0);
                    if (op == 11) m_pc = nxt;
                end
                13: m_out = m_acc;
                14, 15: begin
                    m_acc = 15 - (m_acc & b); m_c = 0; m_z = (m_acc == 0);
                    if (op == 15) m_pc = nxt;
                end
                16: begin
                    if (stk.size() == SD) begin m_err = 1; m_halt = 1; end
                    else begin stk.push_back(nxt); m_pc = tgt; end
                end
                17: begin
                    if (stk.size() == 0) begin m_err = 1; m_halt = 1; end
                    else m_pc = stk.pop_back();
                end
                18: m_halt = 1;
                default: ;
            endcase
            exp_q.push_back({12'(m_pc), 4'(m_acc), m_c, m_z, 4'(m_out), 2'(stk.size()), m_err, m_halt});
            steps++;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("reset-state", {4'd0, pmem_addr, accu, c_flag, z_flag, out_port, sp, stack_err, halted, phase, dmem_we},
              32'd0);
        exp_q.delete();
        wr_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Gives exactly 'edges' clock edges with run=1, interleaved with random stall cycles.
    task automatic drive(input int edges, input int stall_pct);
        int got = 0;
        int guard = 0;
        bit r;
        while (got < edges && guard < 20000) begin
            r   = ($urandom_range(99) >= stall_pct);
            run = r;
            @(posedge clk); #1;
            if (r) got++;
            guard++;
        end
        run = 1'b0;
        if (got < edges) check("drive-budget", got, edges);
    endtask

    task automatic go(input int n, input int stall_pct);
        int steps;
        reset_dut();
        model_init();
        model_run(n, steps);
        drive(2 * steps, stall_pct);
        repeat (2) @(posedge clk);
        #1;
        check("drain-retire", exp_q.size(), 0);
        check("drain-write", wr_q.size(), 0);
    endtask

    initial begin
        int steps;

        // LIT 5; ADDI C -> 17 wraps to 1 with carry
        load_nop();
        pmem[0] = 9'h045; pmem[1] = 9'h0AC;
        go(2, 0);
        check("lit-addi", {accu, c_flag, z_flag, pmem_addr}, {4'h1, 1'b1, 1'b0, 12'd2});

        // CMPI equal, then CMPI greater (borrow)
        load_nop();
        pmem[0] = 9'h043; pmem[1] = 9'h023; pmem[2] = 9'h024;
        go(2, 0);
        check("cmpi-eq", {accu, c_flag, z_flag}, {4'h3, 1'b0, 1'b1});
        go(3, 0);
        check("cmpi-lt", {accu, c_flag, z_flag}, {4'h3, 1'b1, 1'b0});

        // LIT 9; ST 0x234; LIT 0; LD 0x234; OUT
        load_nop();
        pmem[0] = 9'h049; pmem[1] = 9'h071; pmem[2] = 9'h034; pmem[3] = 9'h040;
        pmem[4] = 9'h061; pmem[5] = 9'h034; pmem[6] = 9'h0D0;
        go(5, 30);
        check("st-ld-out", {out_port, accu, dmem[12'h234]}, {4'h9, 4'h9, 4'h9});

        // CALL 0x010; RET
        load_nop();
        pmem[0] = 9'h100; pmem[1] = 9'h010; pmem[12'h010] = 9'h110;
        go(2, 0);
        check("call-ret", {pmem_addr, 2'(sp)}, {12'd2, 2'd0});

        // Three nested CALLs against a two-entry stack
        load_nop();
        pmem[0] = 9'h100;       pmem[1] = 9'h010;
        pmem[12'h010] = 9'h100; pmem[12'h011] = 9'h020;
        pmem[12'h020] = 9'h100; pmem[12'h021] = 9'h030;
        go(3, 0);
        drive(6, 0);
        check("call-overflow", {pmem_addr, 2'(sp), stack_err, halted, phase}, {12'h021, 2'd2, 1'b1, 1'b1, 1'b0});

        // RET with empty stack
        load_nop();
        pmem[0] = 9'h110;
        go(1, 0);
        check("ret-underflow", {pmem_addr, 2'(sp), stack_err, halted}, {12'd1, 2'd0, 1'b1, 1'b1});

        // Stall in ST EXEC, then reset while the write strobe is up
        load_nop();
        pmem[0] = 9'h049; pmem[1] = 9'h071; pmem[2] = 9'h034;
        dmem[12'h234] = 4'h5;
        reset_dut();
        model_init();
        model_run(1, steps);
        drive(3, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall-hold", {pmem_addr, phase, accu, dmem_we}, {12'd2, 1'b1, 4'h9, 1'b0});
        end
        run = 1'b1;
        #1;
        check("st-strobe", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 12'h234, 4'h9});
        #1 reset = 1'b1;
        #1;
        check("reset-we", {31'd0, dmem_we}, 32'd0);
        @(posedge clk); #1;
        check("reset-hold", {4'd0, pmem_addr, accu, c_flag, z_flag, out_port, sp, stack_err, halted, phase, dmem_we},
              32'd0);
        check("reset-nowrite", {28'd0, dmem[12'h234]}, 32'h5);
        run = 1'b0;
        reset = 1'b0;

        // Randomised programs over the whole address space, with random stalls
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 4096; i++) begin
                pmem[i] = 9'($urandom_range(511));
                dmem[i] = 4'($urandom_range(15));
            end
            pushbuttons = 4'($urandom_range(15));
            go(30, 25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
